// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: CP0 exception/interrupt front end.
// Picks one event per accept window (exception > ERET > interrupt). It then emits
// the Cause/EPC/Status update strobes, holds a pipeline flush, and finally
// redirects the fetch PC to the exception vector or to the ERET target.
module exc_irq_ctrl #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  ip_hw_in,
   input  logic [1:0]  sw_ip,
   input  logic        ie,
   input  logic        exl,
   input  logic [7:0]  im,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        commit_bd,
   input  logic        exc_req,
   input  logic [4:0]  exc_code_in,
   input  logic        eret,
   input  logic [31:0] epc_in,
   output logic        exception_abort,
   output logic [4:0]  exception_code,
   output logic        bd_p,
   output logic        irq_h,
   output logic        irq_s,
   output logic [5:0]  ip_h,
   output logic [1:0]  ip_s,
   output logic        epc_we,
   output logic [31:0] epc_wdata,
   output logic        exl_set,
   output logic        exl_clr,
   output logic        flush,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_FLUSH,
      S_REDIR
   } state_e;

   // One-cycle Cause/EPC/Status update presented during ENTRY.
   typedef struct packed {
      logic        abort;
      logic [4:0]  code;
      logic        bd;
      logic        irq_h;
      logic        irq_s;
      logic [5:0]  ip_h;
      logic [1:0]  ip_s;
      logic        epc_we;
      logic [31:0] epc_wdata;
      logic        exl_set;
      logic        exl_clr;
   } entry_t;

   logic [SYNC_STAGES-1:0][5:0] sync_q;
   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        is_eret_q, is_eret_d;
   logic [31:0]                 ret_pc_q, ret_pc_d;
   entry_t                      entry_q, entry_d;
   logic                        flush_q, flush_d;
   logic                        redir_q, redir_d;
   logic [31:0]                 redirect_pc_q, redirect_pc_d;

   logic [5:0]  pend_h;
   logic [1:0]  pend_s;
   logic        int_ok;
   logic [31:0] epc_value;

   assign pend_h    = sync_q[SYNC_STAGES-1] & im[7:2];
   assign pend_s    = sw_ip & im[1:0];
   assign int_ok    = ie & ~exl & (|{pend_h, pend_s});
   // A delay-slot instruction restarts at its branch, one word earlier.
   assign epc_value = commit_bd ? (commit_pc - 32'd4) : commit_pc;

   // Synchronizer chain for the asynchronous hardware interrupt lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
         sync_q <= {sync_q[SYNC_STAGES-2:0], ip_hw_in};
      end
   end

   // FSM state, flush counter and the captured ERET context.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_eret_q <= 1'b0;
         ret_pc_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_eret_q <= is_eret_d;
         ret_pc_q  <= ret_pc_d;
      end
   end

   // Registered outputs, so every strobe is glitch-free and exactly one cycle wide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q       <= '0;
         flush_q       <= 1'b0;
         redir_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         entry_q       <= entry_d;
         flush_q       <= flush_d;
         redir_q       <= redir_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   // Next state, and the output values the registers present in the following cycle.
   always_comb begin
      // NOTE: every signal is given a default before the case so no path leaves it unassigned (no latch).
      state_d       = state_q;
      cnt_d         = cnt_q;
      is_eret_d     = is_eret_q;
      ret_pc_d      = ret_pc_q;
      entry_d       = '0;
      flush_d       = 1'b0;
      redir_d       = 1'b0;
      redirect_pc_d = redirect_pc_q;

      case (state_q)
         S_IDLE: begin
            if (commit_valid && (exc_req || eret || int_ok)) begin
               state_d = S_ENTRY;
               flush_d = 1'b1;
               if (exc_req) begin
                  is_eret_d         = 1'b0;
                  entry_d.abort     = 1'b1;
                  entry_d.code      = exc_code_in;
                  entry_d.bd        = commit_bd;
                  entry_d.exl_set   = 1'b1;
                  entry_d.epc_we    = ~exl;
                  entry_d.epc_wdata = epc_value;
               end else if (eret) begin
                  is_eret_d       = 1'b1;
                  ret_pc_d        = epc_in;
                  entry_d.exl_clr = 1'b1;
               end else begin
                  // Interrupt: the commit instruction is cancelled and restarts from EPC.
                  is_eret_d         = 1'b0;
                  entry_d.abort     = 1'b1;
                  entry_d.code      = 5'd0;
                  entry_d.bd        = commit_bd;
                  entry_d.exl_set   = 1'b1;
                  entry_d.irq_h     = |pend_h;
                  entry_d.ip_h      = pend_h;
                  entry_d.irq_s     = |pend_s;
                  entry_d.ip_s      = pend_s;
                  entry_d.epc_we    = ~exl;
                  entry_d.epc_wdata = epc_value;
               end
            end
         end
         S_ENTRY: begin
            state_d = S_FLUSH;
            cnt_d   = '0;
            flush_d = 1'b1;
         end
         S_FLUSH: begin
            if (cnt_q == CNT_LAST) begin
               state_d       = S_REDIR;
               redir_d       = 1'b1;
               redirect_pc_d = is_eret_q ? ret_pc_q : EXC_VECTOR;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               flush_d = 1'b1;
            end
         end
         S_REDIR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign exception_abort = entry_q.abort;
   assign exception_code  = entry_q.code;
   assign bd_p            = entry_q.bd;
   assign irq_h           = entry_q.irq_h;
   assign irq_s           = entry_q.irq_s;
   assign ip_h            = entry_q.ip_h;
   assign ip_s            = entry_q.ip_s;
   assign epc_we          = entry_q.epc_we;
   assign epc_wdata       = entry_q.epc_wdata;
   assign exl_set         = entry_q.exl_set;
   assign exl_clr         = entry_q.exl_clr;
   assign flush           = flush_q;
   assign pc_redirect     = redir_q;
   assign redirect_pc     = redirect_pc_q;
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// tb_exc_irq_ctrl: directed scenarios plus a randomized run checked against a
// cycle-schedule reference model of the exception/interrupt front end.
module tb_exc_irq_ctrl;

   localparam int          SS  = 2;
   localparam int          FC  = 2;
   localparam logic [31:0] VEC = 32'hBFC00380;

   logic        clk, rst;
   logic [5:0]  ip_hw_in;
   logic [1:0]  sw_ip;
   logic        ie, exl;
   logic [7:0]  im;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        commit_bd;
   logic        exc_req;
   logic [4:0]  exc_code_in;
   logic        eret;
   logic [31:0] epc_in;
   logic        exception_abort;
   logic [4:0]  exception_code;
   logic        bd_p, irq_h, irq_s;
   logic [5:0]  ip_h;
   logic [1:0]  ip_s;
   logic        epc_we;
   logic [31:0] epc_wdata;
   logic        exl_set, exl_clr, flush, pc_redirect;
   logic [31:0] redirect_pc;
   logic        busy;

   typedef struct packed {
      logic        abort;
      logic [4:0]  code;
      logic        bd;
      logic        irq_h;
      logic        irq_s;
      logic [5:0]  ip_h;
      logic [1:0]  ip_s;
      logic        epc_we;
      logic [31:0] epc_wdata;
      logic        exl_set;
      logic        exl_clr;
      logic        flush;
      logic        pc_redirect;
      logic [31:0] redirect_pc;
      logic        busy;
   } out_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] lrpc    = '0;   // last redirect target the bench expects to be held

   exc_irq_ctrl #(.SYNC_STAGES(SS), .FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)) dut (
      .clk(clk), .rst(rst), .ip_hw_in(ip_hw_in), .sw_ip(sw_ip), .ie(ie), .exl(exl), .im(im),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
      .exc_req(exc_req), .exc_code_in(exc_code_in), .eret(eret), .epc_in(epc_in),
      .exception_abort(exception_abort), .exception_code(exception_code), .bd_p(bd_p),
      .irq_h(irq_h), .irq_s(irq_s), .ip_h(ip_h), .ip_s(ip_s), .epc_we(epc_we),
      .epc_wdata(epc_wdata), .exl_set(exl_set), .exl_clr(exl_clr), .flush(flush),
      .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic out_t observe();
      out_t o;
      o.abort = exception_abort;  o.code = exception_code;  o.bd = bd_p;
      o.irq_h = irq_h;  o.irq_s = irq_s;  o.ip_h = ip_h;  o.ip_s = ip_s;
      o.epc_we = epc_we;  o.epc_wdata = epc_wdata;  o.exl_set = exl_set;  o.exl_clr = exl_clr;
      o.flush = flush;  o.pc_redirect = pc_redirect;  o.redirect_pc = redirect_pc;  o.busy = busy;
      return o;
   endfunction

   // Expected outputs k cycles after an accept: ENTRY, FC flush cycles, REDIR, then idle.
   function automatic out_t seq_exp(out_t entry, int k, logic [31:0] tgt, logic [31:0] prev);
      out_t e = '0;
      if (k == 0) begin
         e = entry;  e.flush = 1'b1;  e.busy = 1'b1;  e.redirect_pc = prev;
      end else if (k <= FC) begin
         e.flush = 1'b1;  e.busy = 1'b1;  e.redirect_pc = prev;
      end else if (k == FC + 1) begin
         e.pc_redirect = 1'b1;  e.busy = 1'b1;  e.redirect_pc = tgt;
      end else begin
         e.redirect_pc = tgt;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ip_hw_in = '0;  sw_ip = '0;  ie = 1'b0;  exl = 1'b0;  im = '0;
      commit_valid = 1'b0;  commit_pc = '0;  commit_bd = 1'b0;
      exc_req = 1'b0;  exc_code_in = '0;  eret = 1'b0;  epc_in = '0;
   endtask

   task automatic test_reset();
      out_t obs;
      bit   bad = 0;
      rst = 1'b1;
      clear_inputs();
      repeat (3) tick();
      obs = observe();
      n_tests++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected 0", obs);
      end
      rst = 1'b0;
      tick();
      commit_valid = 1'b1;  exc_req = 1'b1;  exc_code_in = 5'd4;  commit_pc = 32'h1234;
      tick();               // ENTRY
      clear_inputs();
      tick();               // first FLUSH cycle
      #3 rst = 1'b1;
      #1 obs = observe();
      n_tests++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_async_mid_flush: got %h expected 0", obs);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         obs = observe();
         if (obs !== '0) bad = 1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL reset_no_redirect_after: got %h expected 0", obs);
      end
      lrpc = '0;
   endtask

   typedef struct {
      logic [4:0]  code;
      logic [31:0] pc;
      logic        bd;
      logic        exl;
      logic [31:0] wdata;
      logic        we;
   } exc_case_t;

   task automatic test_exception();
      exc_case_t cs[3];
      out_t      en, obs, exp;
      cs[0] = '{5'd12, 32'h80000100, 1'b0, 1'b0, 32'h80000100, 1'b1};
      cs[1] = '{5'd4,  32'h00000000, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b1};
      cs[2] = '{5'd8,  32'h80000300, 1'b0, 1'b1, 32'h80000300, 1'b0};   // nested: exl=1
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         commit_valid = 1'b1;  exc_req = 1'b1;  exc_code_in = cs[c].code;
         commit_pc = cs[c].pc;  commit_bd = cs[c].bd;  exl = cs[c].exl;
         tick();
         clear_inputs();
         en = '0;  en.abort = 1'b1;  en.code = cs[c].code;  en.bd = cs[c].bd;  en.exl_set = 1'b1;
         en.epc_we = cs[c].we;  en.epc_wdata = cs[c].wdata;
         for (int k = 0; k <= FC + 2; k++) begin
            obs = observe();
            exp = seq_exp(en, k, VEC, lrpc);
            n_tests++;
            if (obs !== exp) begin
               n_fail++;
               $display("FAIL exception case %0d cycle %0d: got %h expected %h", c, k, obs, exp);
            end
            if (k < FC + 2) tick();
         end
         lrpc = VEC;
      end
   endtask

   typedef struct {
      logic [5:0]  ip;
      logic [1:0]  sw;
      logic [7:0]  imv;
      logic [31:0] pc;
      logic        bd;
      logic [31:0] wdata;
      bit          taken;
      int          lat;    // idle cycles before the accept edge
   } irq_case_t;

   task automatic test_interrupt();
      irq_case_t cs[3];
      out_t      en, obs, exp;
      cs[0] = '{6'b000100, 2'b00, 8'h10, 32'h80000404, 1'b1, 32'h80000400, 1'b1, SS};
      cs[1] = '{6'b000000, 2'b01, 8'h01, 32'h80000600, 1'b0, 32'h80000600, 1'b1, 0};
      cs[2] = '{6'b000100, 2'b11, 8'h00, 32'h80000700, 1'b0, 32'h80000700, 1'b0, 6};
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         ip_hw_in = cs[c].ip;  sw_ip = cs[c].sw;  im = cs[c].imv;  ie = 1'b1;
         commit_valid = 1'b1;  commit_pc = cs[c].pc;  commit_bd = cs[c].bd;
         for (int w = 0; w < cs[c].lat; w++) begin
            tick();
            obs = observe();
            exp = '0;  exp.redirect_pc = lrpc;
            n_tests++;
            if (obs !== exp) begin
               n_fail++;
               $display("FAIL interrupt case %0d wait %0d: got %h expected %h", c, w, obs, exp);
            end
         end
         if (cs[c].taken) begin
            tick();
            clear_inputs();
            en = '0;  en.abort = 1'b1;  en.code = 5'd0;  en.bd = cs[c].bd;  en.exl_set = 1'b1;
            en.irq_h = (cs[c].ip & cs[c].imv[7:2]) != 0;  en.ip_h = cs[c].ip & cs[c].imv[7:2];
            en.irq_s = (cs[c].sw & cs[c].imv[1:0]) != 0;  en.ip_s = cs[c].sw & cs[c].imv[1:0];
            en.epc_we = 1'b1;  en.epc_wdata = cs[c].wdata;
            for (int k = 0; k <= FC + 2; k++) begin
               obs = observe();
               exp = seq_exp(en, k, VEC, lrpc);
               n_tests++;
               if (obs !== exp) begin
                  n_fail++;
                  $display("FAIL interrupt case %0d cycle %0d: got %h expected %h", c, k, obs, exp);
               end
               if (k < FC + 2) tick();
            end
            lrpc = VEC;
         end
      end
      clear_inputs();
   endtask

   task automatic test_priority();
      out_t en, obs, exp;
      clear_inputs();
      ip_hw_in = 6'b100000;  sw_ip = 2'b01;  im = 8'h81;  ie = 1'b1;
      repeat (SS + 1) tick();
      commit_valid = 1'b1;  exc_req = 1'b1;  eret = 1'b1;  exc_code_in = 5'd10;
      commit_pc = 32'h80000500;  epc_in = 32'h12345678;
      tick();
      en = '0;  en.abort = 1'b1;  en.code = 5'd10;  en.exl_set = 1'b1;
      en.epc_we = 1'b1;  en.epc_wdata = 32'h80000500;
      for (int k = 0; k <= FC + 2; k++) begin
         obs = observe();
         exp = seq_exp(en, k, VEC, lrpc);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL priority_busy_ignore cycle %0d: got %h expected %h", k, obs, exp);
         end
         // Requests presented while busy must be ignored.
         commit_valid = 1'b1;  exc_req = 1'b1;  eret = 1'($urandom);
         exc_code_in = 5'($urandom);  commit_pc = $urandom;  epc_in = $urandom;
         if (k == FC + 2) clear_inputs();
         if (k < FC + 2) tick();
      end
      lrpc = VEC;
   endtask

   task automatic test_eret();
      out_t en, obs, exp;
      clear_inputs();
      commit_valid = 1'b1;  eret = 1'b1;  exl = 1'b1;  epc_in = 32'h80000200;
      commit_pc = 32'h80000900;  ie = 1'b1;  sw_ip = 2'b11;  im = 8'hFF;
      tick();
      clear_inputs();
      en = '0;  en.exl_clr = 1'b1;
      for (int k = 0; k <= FC + 2; k++) begin
         obs = observe();
         exp = seq_exp(en, k, 32'h80000200, lrpc);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL eret cycle %0d: got %h expected %h", k, obs, exp);
         end
         if (k < FC + 2) tick();
      end
      lrpc = 32'h80000200;
      // Interrupts stay masked while exl=1.
      commit_valid = 1'b1;  ie = 1'b1;  exl = 1'b1;  sw_ip = 2'b11;  im = 8'hFF;
      for (int w = 0; w < 5; w++) begin
         tick();
         obs = observe();
         exp = '0;  exp.redirect_pc = lrpc;
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL irq_masked_by_exl wait %0d: got %h expected %h", w, obs, exp);
         end
      end
      clear_inputs();
   endtask

   // Random traffic against a model that schedules each accepted event's outputs into future cycles.
   task automatic test_random();
      out_t        sched[16];
      bit          sched_v[16];
      logic [5:0]  hist[$];
      logic [5:0]  synced, ph;
      logic [1:0]  ps;
      logic [31:0] tgt, mrpc;
      out_t        en, obs, exp;
      int          e, free_e, slot;
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back(6'd0);
      for (int i = 0; i < 16; i++) sched_v[i] = 0;
      e = 0;  free_e = 0;  mrpc = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         commit_valid = ($urandom_range(0, 3) != 0);
         exc_req      = ($urandom_range(0, 7) == 0);
         eret         = ($urandom_range(0, 7) == 0);
         exc_code_in  = 5'($urandom);
         commit_pc    = $urandom;
         commit_bd    = 1'($urandom);
         epc_in       = $urandom;
         ie           = ($urandom_range(0, 3) != 0);
         exl          = ($urandom_range(0, 3) == 0);
         im           = 8'($urandom);
         if ($urandom_range(0, 5) == 0) ip_hw_in = 6'($urandom);
         sw_ip        = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         e++;
         synced = hist.pop_front();
         hist.push_back(ip_hw_in);
         ph = synced & im[7:2];
         ps = sw_ip & im[1:0];
         if (e >= free_e && commit_valid &&
             (exc_req || eret || (ie && !exl && (ph != 0 || ps != 0)))) begin
            en = '0;
            if (exc_req) begin
               en.abort = 1'b1;  en.code = exc_code_in;  en.bd = commit_bd;  en.exl_set = 1'b1;
               en.epc_we = !exl;  en.epc_wdata = commit_bd ? commit_pc - 32'd4 : commit_pc;
               tgt = VEC;
            end else if (eret) begin
               en.exl_clr = 1'b1;
               tgt = epc_in;
            end else begin
               en.abort = 1'b1;  en.code = 5'd0;  en.bd = commit_bd;  en.exl_set = 1'b1;
               en.irq_h = (ph != 0);  en.ip_h = ph;  en.irq_s = (ps != 0);  en.ip_s = ps;
               en.epc_we = 1'b1;  en.epc_wdata = commit_bd ? commit_pc - 32'd4 : commit_pc;
               tgt = VEC;
            end
            for (int j = 0; j <= FC + 1; j++) begin
               sched[(e + j) % 16]   = seq_exp(en, j, tgt, '0);
               sched_v[(e + j) % 16] = 1;
            end
            free_e = e + FC + 3;
         end
         tick();
         slot = e % 16;
         exp = sched_v[slot] ? sched[slot] : out_t'('0);
         sched_v[slot] = 0;
         if (exp.pc_redirect) mrpc = exp.redirect_pc;
         exp.redirect_pc = mrpc;
         obs = observe();
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL random cycle %0d: got %h expected %h", cyc, obs, exp);
         end
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_exception();
      test_interrupt();
      test_priority();
      test_eret();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
